// File: rtl/spi_pkg.sv
// Shared constants, state encoding and frame layout for the register SPI link.
package spi_pkg;

  localparam logic [7:0] SPI_SFD         = 8'hD5;
  localparam int         SPI_FRAME_BYTES = 5;
  localparam logic [7:0] SPI_ACK_BYTE    = 8'h00;

  // Byte positions inside one frame.
  localparam logic [2:0] BYTE_SFD0 = 3'd0;
  localparam logic [2:0] BYTE_SFD1 = 3'd1;
  localparam logic [2:0] BYTE_CMD  = 3'd2;
  localparam logic [2:0] BYTE_DHI  = 3'd3;
  localparam logic [2:0] BYTE_DLO  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_GAP       = 3'd3,
    ST_HOLD      = 3'd4,
    ST_IDLE_WAIT = 3'd5
  } spi_state_e;

  // MOSI byte for a given frame position; positions past the frame give 0 so
  // the line rests low once the last byte is out.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic        we,
                                            input logic [6:0]  addr,
                                            input logic [15:0] wdata);
    logic [7:0] b;
    case (idx)
      BYTE_SFD0: b = SPI_SFD;
      BYTE_SFD1: b = SPI_SFD;
      BYTE_CMD:  b = {we, addr};
      BYTE_DHI:  b = wdata[15:8];
      BYTE_DLO:  b = wdata[7:0];
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_master_shift.sv
// 8-bit SPI mode-0 shift engine: SCK divider, MSB-first MOSI, MISO sampling
// on SCK rise through a 2-flop synchroniser.
//
// Handshake: load_i (any cycle, SCK low) copies din_i into the TX shifter so
// MOSI shows its MSB at once; start_i (only while the engine is idle) begins
// 8 SCK periods. byte_done_o is high for exactly one cycle, the cycle whose
// closing clk edge produces the 8th falling SCK edge; rx_o holds the full
// received byte during that cycle and until the next byte starts shifting.
module spi_master_shift #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] din_i,
  input  logic       start_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic [7:0] rx_o,
  output logic       byte_done_o
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          sck_q;
  logic          active_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic [7:0]    rx_q;
  logic [1:0]    miso_sync_q;
  logic          half_end;

  assign half_end    = active_q && (div_q == '0);
  assign byte_done_o = half_end && sck_q && (bit_q == 3'd0);
  assign sck_o       = sck_q;
  assign mosi_o      = sh_q[7];
  assign rx_o        = rx_q;

  // Bring the asynchronous MISO line into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_sync_q <= 2'b00;
    else        miso_sync_q <= {miso_sync_q[0], miso_i};
  end

  // Divider, SCK toggling, TX shift on fall and RX sample on rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      sck_q    <= 1'b0;
      active_q <= 1'b0;
      bit_q    <= 3'd0;
      sh_q     <= 8'h00;
      rx_q     <= 8'h00;
    end else begin
      if (start_i) begin
        active_q <= 1'b1;
        div_q    <= DIV_LAST;
        bit_q    <= 3'd7;
        sck_q    <= 1'b0;
      end else if (active_q) begin
        if (div_q != '0) begin
          div_q <= div_q - DW'(1);
        end else begin
          div_q <= DIV_LAST;
          if (!sck_q) begin
            sck_q <= 1'b1;
            rx_q  <= {rx_q[6:0], miso_sync_q[1]};
          end else begin
            sck_q <= 1'b0;
            if (bit_q == 3'd0) begin
              active_q <= 1'b0;
            end else begin
              bit_q <= bit_q - 3'd1;
              sh_q  <= {sh_q[6:0], 1'b0};
            end
          end
        end
      end
      // A load never coincides with a shift: it only comes while idle or on
      // the final falling edge, where no shift happens.
      if (load_i) sh_q <= din_i;
    end
  end

endmodule

// File: rtl/spi_master_access.sv
// Frame controller for the register SPI initiator: accepts one bus request,
// sends {D5, D5, {we,addr}, wdata_hi, wdata_lo}, checks the slave echo bytes
// and returns the 16-bit read value.
//
// Request handshake: req is a level sampled only in IDLE; the cycle it is
// seen there the request is accepted (busy rises, csb falls) and the inputs
// are latched. done pulses for one cycle when the frame is complete, with
// rdata/err valid from then until the next done.
module spi_master_access
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 16,
  parameter int BYTE_GAP = 8,
  parameter int CS_IDLE  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        sck,
  output logic        csb,
  output logic        mosi,
  input  logic        miso,
  output spi_state_e  state
);

  // One timer serves every timed state; HOLD runs CLK_DIV+1 cycles so the
  // final cycle can register the result while SCK has rested CLK_DIV cycles.
  localparam int T01  = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
  localparam int T23  = (CS_IDLE > CLK_DIV + 1) ? CS_IDLE : CLK_DIV + 1;
  localparam int TMAX = (T01 > T23) ? T01 : T23;
  localparam int TW   = $clog2(TMAX + 1);

  spi_state_e  state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_load;
  logic          tmr_done;
  logic [2:0]    idx_q;
  logic          we_q;
  logic [6:0]    addr_q;
  logic [15:0]   wdata_q;
  logic          busy_q, done_q, err_q, csb_q;
  logic [15:0]   rdata_q;
  logic          e1_q, e2_q;
  logic [7:0]    rhi_q, rlo_q;

  logic          accept, start, load, frame_end, byte_done;
  logic [7:0]    din, rx_byte;

  assign tmr_done = (tmr_q == '0);
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign csb      = csb_q;
  assign state    = state_q;

  spi_master_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .din_i       (din),
    .start_i     (start),
    .miso_i      (miso),
    .sck_o       (sck),
    .mosi_o      (mosi),
    .rx_o        (rx_byte),
    .byte_done_o (byte_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic for the frame sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req)       state_d = ST_SETUP;
      ST_SETUP:     if (tmr_done)  state_d = ST_SHIFT;
      ST_SHIFT:     if (byte_done) state_d = (idx_q == 3'(SPI_FRAME_BYTES - 1)) ? ST_HOLD : ST_GAP;
      ST_GAP:       if (tmr_done)  state_d = ST_SHIFT;
      ST_HOLD:      if (tmr_done)  state_d = ST_IDLE_WAIT;
      ST_IDLE_WAIT: if (tmr_done)  state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Per-state strobes, shift-engine controls and timer reload value.
  always_comb begin
    accept    = (state_q == ST_IDLE) && req;
    start     = ((state_q == ST_SETUP) || (state_q == ST_GAP)) && tmr_done;
    frame_end = (state_q == ST_HOLD) && tmr_done;
    load      = accept || byte_done;
    din       = accept ? SPI_SFD : frame_byte(idx_q + 3'd1, we_q, addr_q, wdata_q);
    case (state_d)
      ST_SETUP:     tmr_load = TW'(CS_SETUP - 1);
      ST_GAP:       tmr_load = TW'(BYTE_GAP - 1);
      ST_HOLD:      tmr_load = TW'(CLK_DIV);
      ST_IDLE_WAIT: tmr_load = TW'(CS_IDLE - 1);
      default:      tmr_load = '0;
    endcase
  end

  // Timer, request latch, byte index, echo checks and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q   <= '0;
      idx_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 7'h00;
      wdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      csb_q   <= 1'b1;
      rdata_q <= 16'h0000;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      rhi_q   <= 8'h00;
      rlo_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (state_d != state_q)  tmr_q <= tmr_load;
      else if (!tmr_done)      tmr_q <= tmr_q - TW'(1);

      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        busy_q  <= 1'b1;
        csb_q   <= 1'b0;
        idx_q   <= 3'd0;
      end

      if (byte_done) begin
        idx_q <= idx_q + 3'd1;
        case (idx_q)
          BYTE_SFD1: e1_q  <= (rx_byte != SPI_SFD);
          BYTE_CMD:  e2_q  <= (rx_byte != SPI_ACK_BYTE);
          BYTE_DHI:  rhi_q <= rx_byte;
          BYTE_DLO:  rlo_q <= rx_byte;
          default: ;
        endcase
      end

      if (frame_end) begin
        csb_q   <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        rdata_q <= {rhi_q, rlo_q};
        err_q   <= e1_q | e2_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_access.sv
// Directed bench for spi_master_access: table of frames against a mode-0
// slave model, plus held-request and mid-frame reset sequences.
module tb_spi_master_access;
  import spi_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 16;
  localparam int BYTE_GAP = 8;
  localparam int CS_IDLE  = 32;
  localparam int LATENCY  = CS_SETUP + 5*16*CLK_DIV + 4*BYTE_GAP + CLK_DIV + 1;
  localparam int BUDGET   = 2000;

  logic        clk, rst_n, req, we, miso;
  logic [6:0]  addr;
  logic [15:0] wdata;
  logic        busy, done, err, sck, csb, mosi;
  logic [15:0] rdata;
  spi_state_e  state;

  int checks   = 0;
  int failures = 0;
  logic [39:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  spi_master_access #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err), .sck(sck), .csb(csb),
    .mosi(mosi), .miso(miso), .state(state)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- slave model + MOSI monitor / scoreboard ----------------
  logic [7:0]  s_tx [5];
  int          s_byte, s_bit, mon_bits;
  logic [39:0] mon_frame;
  bit          mon_active = 0;
  bit          abort_ok   = 0;

  initial miso = 1'b0;

  always @(negedge csb) begin
    mon_active = 1;
    mon_bits   = 0;
    mon_frame  = '0;
    s_byte     = 0;
    s_bit      = 7;
    miso       = s_tx[0][7];
  end

  always @(posedge sck) if (!csb) begin
    mon_frame = {mon_frame[38:0], mosi};
    mon_bits++;
  end

  always @(negedge sck) if (!csb) begin
    if (s_bit == 0) begin
      s_bit = 7;
      if (s_byte < 4) s_byte++;
    end else begin
      s_bit--;
    end
    miso = s_tx[s_byte][s_bit];
  end

  always @(posedge csb) if (mon_active) begin
    mon_active = 0;
    miso       = 1'b0;
    if (mon_bits == 40) begin
      if (exp_q.size() == 0) check("mosi_unexpected_frame", mon_frame, 40'h0);
      else                   check("mosi_frame", mon_frame, exp_q.pop_front());
    end else if (!abort_ok) begin
      check("frame_len", 40'(mon_bits), 40'd40);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  s1, s2, s3, s4;
    logic [39:0] exp_mosi;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic set_slave(input vec_t v);
    s_tx[0] = 8'h00; s_tx[1] = v.s1; s_tx[2] = v.s2; s_tx[3] = v.s3; s_tx[4] = v.s4;
  endtask

  // Wait (bounded) for done, sampling #1 after each rising edge.
  task automatic wait_done(output int n, output bit got);
    n = 0; got = 0;
    while (!got && n < BUDGET) begin
      @(posedge clk); n++; #1;
      if (done) got = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input vec_t v);
    int n; bit got;
    set_slave(v);
    @(negedge clk);
    we = v.we; addr = v.addr; wdata = v.wdata; req = 1'b1;
    exp_q.push_back(v.exp_mosi);
    @(posedge clk); #1;
    check("busy_accept", busy, 1'b1);
    req = 1'b0;
    n = 0; got = 0;
    while (!got && n < BUDGET) begin
      @(posedge clk); n++; #1;
      if (n == 50) begin addr = ~v.addr; wdata = ~v.wdata; we = ~v.we; end
      if (done) got = 1;
    end
    check("done_seen", got, 1'b1);
    check("latency", 40'(n), 40'(LATENCY));
    check("rdata", rdata, v.exp_rdata);
    check("err", err, v.exp_err);
    check("busy_at_done", busy, 1'b0);
    check("csb_at_done", csb, 1'b1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    repeat (CS_IDLE + 2) @(posedge clk);
  endtask

  initial begin
    int n, gap, sck_hi;
    bit got;

    vecs[0] = '{1'b1, 7'h12, 16'hBEEF, 8'hD5, 8'h00, 8'hAB, 8'hCD, 40'hD5D592BEEF, 16'hABCD, 1'b0};
    vecs[1] = '{1'b0, 7'h12, 16'h0000, 8'hD5, 8'h00, 8'h12, 8'h34, 40'hD5D5120000, 16'h1234, 1'b0};
    vecs[2] = '{1'b0, 7'h7F, 16'h5A5A, 8'hFF, 8'h00, 8'h56, 8'h78, 40'hD5D57F5A5A, 16'h5678, 1'b1};
    vecs[3] = '{1'b1, 7'h00, 16'h0001, 8'hD5, 8'h01, 8'h9A, 8'hBC, 40'hD5D5800001, 16'h9ABC, 1'b1};
    vecs[4] = '{1'b0, 7'h55, 16'hFFFF, 8'hD5, 8'h00, 8'h00, 8'h00, 40'hD5D555FFFF, 16'h0000, 1'b0};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    set_slave(vecs[1]);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata_err", {rdata, err}, 17'h0);
    check("rst_spi_pins", {sck, csb, mosi}, 3'b010);
    check("rst_state", state, ST_IDLE);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // req held high across three frames: CS idle gap and SCK rest between them.
    set_slave(vecs[1]);
    @(negedge clk);
    we = 1'b0; addr = 7'h12; wdata = 16'h0000; req = 1'b1;
    for (int f = 0; f < 3; f++) exp_q.push_back(40'hD5D5120000);
    for (int f = 0; f < 3; f++) begin
      wait_done(n, got);
      check("held_done_seen", got, 1'b1);
      check("held_busy_drop", busy, 1'b0);
      check("held_rdata", rdata, 16'h1234);
      if (f == 2) begin
        req = 1'b0;
      end else begin
        gap = 1; sck_hi = 0;
        while (csb && gap < BUDGET) begin
          @(posedge clk); #1;
          if (sck) sck_hi++;
          if (csb) gap++;
        end
        check("held_cs_idle_gap", 40'(gap), 40'(CS_IDLE + 1));
        check("held_sck_idle", 40'(sck_hi), 40'd0);
        check("held_busy_reaccept", busy, 1'b1);
      end
    end
    repeat (CS_IDLE + 2) @(posedge clk);

    // Reset during byte 3 abandons the frame.
    set_slave(vecs[1]);
    abort_ok = 1;
    @(negedge clk);
    we = 1'b0; addr = 7'h33; wdata = 16'hA5A5; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (mon_bits < 28 && n < BUDGET) begin @(posedge clk); n++; end
    check("reach_byte3", 40'(mon_bits >= 28), 40'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_csb_sck", {csb, sck}, 2'b10);
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_rdata_err", {rdata, err}, 17'h0);
    check("abort_state", state, ST_IDLE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    abort_ok = 0;
    got = 0;
    repeat (20) begin @(posedge clk); #1; if (done) got = 1; end
    check("abort_no_done", got, 1'b0);
    run_frame(vecs[2]);

    check("scoreboard_drained", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
